bshifter_pipe: RTL
==================

BSHIFTER_PIPE -- requirements
Module: bshifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; power of two, minimum 4.
REQ-002 SHALL have localparam SHAMT_W = log2(WIDTH), default 3, shift-amount width and pipeline depth.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream presents an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_amt  input  SHAMT_W  shift/rotate amount, 0..WIDTH-1.
REQ-009 SHALL have port in_lr  input  1  direction: 0 right, 1 left.
REQ-010 SHALL have port in_mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved.
REQ-011 SHALL have port out_valid  output  1  out_data holds a result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  WIDTH  result.

Function
REQ-014 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1.
REQ-015 SHALL use SHAMT_W registered stages; stage i shifts by 2^i when amt bit i = 1, else passes data through; amt, lr and mode travel with the data.
REQ-016 SHALL present the result with out_valid = 1 exactly SHAMT_W rising edges after acceptance when not stalled (3 cycles at WIDTH 8).
REQ-017 SHALL sustain one accepted operation per cycle when out_ready is held at 1.
REQ-018 SHALL compute rotate with wrap-around: bits shifted out re-enter at the opposite end.
REQ-019 SHALL compute logical shift with zero fill in both directions.
REQ-020 SHALL compute arithmetic right shift with fill from the operand's original MSB; arithmetic left shift SHALL equal logical left shift.
REQ-021 SHALL treat mode 11 as rotate.
REQ-022 SHALL produce out_data = in_data when in_amt = 0, in every mode.
REQ-023 SHALL stall globally: when out_valid = 1 and out_ready = 0, every stage SHALL hold its contents and in_ready SHALL be 0.
REQ-024 SHALL drive in_ready = !(out_valid && !out_ready), combinationally; bubbles are not collapsed.
REQ-025 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL deliver results in acceptance order, with none lost or duplicated.
REQ-027 SHALL ignore in_data, in_amt, in_lr and in_mode when in_valid = 0 or in_ready = 0.

Reset
REQ-028 SHALL, while rst = 1, clear every stage valid bit and data register to 0 asynchronously: out_valid = 0, out_data = 0.
REQ-029 SHALL drive in_ready = 1 during and immediately after reset.
REQ-030 SHALL discard all in-flight operations when reset is asserted mid-operation, with no partial result emitted after release.

Structure
REQ-031 SHALL take the mode encodings (ROT, LSH, ASH, RSV) from shared package bshifter_pkg.
REQ-032 SHALL implement one stage as sub-module bshifter_stage (parameters WIDTH and STEP = 2^i), instantiated SHAMT_W times by a generate loop.
REQ-033 SHALL carry the operand's original MSB alongside the data for arithmetic fill.

Verification
REQ-034 SHALL show: WIDTH 8, data 10101010, amt 1, lr 0, mode 00 -> out_data 01010101, out_valid exactly 3 cycles after acceptance.
REQ-035 SHALL show: data 10010000, amt 3, lr 0, mode 10 -> 11110010; same with mode 01 -> 00010010.
REQ-036 SHALL show: data 10000001, amt 2, lr 1, mode 01 -> 00000100; mode 00 -> 00000110; mode 11 -> 00000110.
REQ-037 SHALL show: 8 back-to-back operations, out_ready held 1 -> 8 consecutive results in order, one per cycle.
REQ-038 SHALL show: out_ready 0 with 3 operations in flight -> in_ready 0 and out_data held; out_ready 1 -> all 3 results emitted in order.
REQ-039 SHALL show: rst pulsed with 2 operations in flight -> out_valid 0 at once, no stale result after release, new operation correct with 3-cycle latency.

Source files
------------

// File: rtl/bshifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation mode encodings
// and a small helper used by every stage.
package bshifter_pkg;

  typedef enum logic [1:0] {
    ROT = 2'b00,
    LSH = 2'b01,
    ASH = 2'b10,
    RSV = 2'b11
  } mode_e;

  // The reserved encoding behaves exactly like rotate.
  function automatic logic is_rotate(input mode_e m);
    return (m == ROT) || (m == RSV);
  endfunction

endpackage

// File: rtl/bshifter_stage.sv
// One registered barrel-shifter stage: conditionally shifts/rotates by STEP
// and carries the operation's control fields forward alongside the data.
module bshifter_stage
  import bshifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_lr,
  input  mode_e            in_mode,
  input  logic             in_msb,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
  output logic             out_lr,
  output mode_e            out_mode,
  output logic             out_msb
);

  localparam int BIT = $clog2(STEP);

  logic             fill;
  logic [WIDTH-1:0] shifted;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;
  logic [AMT_W-1:0] amt_d,   amt_q;
  logic             lr_d,    lr_q;
  mode_e            mode_d,  mode_q;
  logic             msb_d,   msb_q;

  // Arithmetic right fill comes from the operand's original MSB, not the
  // current data, so partial shifts in earlier stages cannot corrupt it.
  always_comb begin
    fill    = (in_mode == ASH) ? in_msb : 1'b0;
    shifted = in_data;
    if (in_amt[BIT]) begin
      if (in_lr) begin
        if (is_rotate(in_mode)) shifted = {in_data[WIDTH-STEP-1:0], in_data[WIDTH-1:WIDTH-STEP]};
        else                    shifted = {in_data[WIDTH-STEP-1:0], {STEP{1'b0}}};
      end else begin
        if (is_rotate(in_mode)) shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
        else                    shifted = {{STEP{fill}}, in_data[WIDTH-1:STEP]};
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    lr_d    = lr_q;
    mode_d  = mode_q;
    msb_d   = msb_q;
    if (en) begin
      valid_d = in_valid;
      data_d  = shifted;
      amt_d   = in_amt;
      lr_d    = in_lr;
      mode_d  = in_mode;
      msb_d   = in_msb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      lr_q    <= 1'b0;
      mode_q  <= ROT;
      msb_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      lr_q    <= lr_d;
      mode_q  <= mode_d;
      msb_q   <= msb_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_lr    = lr_q;
  assign out_mode  = mode_q;
  assign out_msb   = msb_q;

endmodule

// File: rtl/bshifter_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, stage i moves data
// by 2^i. Valid/ready: a transfer happens on a rising edge where both are 1.
module bshifter_pipe
  import bshifter_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic               in_lr,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  logic               vld  [SHAMT_W+1];
  logic [WIDTH-1:0]   dat  [SHAMT_W+1];
  logic [SHAMT_W-1:0] amt  [SHAMT_W+1];
  logic               lr   [SHAMT_W+1];
  mode_e              mode [SHAMT_W+1];
  logic               msb  [SHAMT_W+1];

  // Global stall: the whole pipe freezes while a result waits downstream;
  // bubbles are not squeezed out.
  assign in_ready = !(out_valid && !out_ready);

  assign vld[0]  = in_valid;
  assign dat[0]  = in_data;
  assign amt[0]  = in_amt;
  assign lr[0]   = in_lr;
  assign mode[0] = mode_e'(in_mode);
  assign msb[0]  = in_data[WIDTH-1];

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    bshifter_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << i),
      .AMT_W (SHAMT_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (in_ready),
      .in_valid  (vld[i]),
      .in_data   (dat[i]),
      .in_amt    (amt[i]),
      .in_lr     (lr[i]),
      .in_mode   (mode[i]),
      .in_msb    (msb[i]),
      .out_valid (vld[i+1]),
      .out_data  (dat[i+1]),
      .out_amt   (amt[i+1]),
      .out_lr    (lr[i+1]),
      .out_mode  (mode[i+1]),
      .out_msb   (msb[i+1])
    );
  end

  assign out_valid = vld[SHAMT_W];
  assign out_data  = dat[SHAMT_W];

  // Control fields leaving the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt[SHAMT_W], lr[SHAMT_W], mode[SHAMT_W], msb[SHAMT_W]};

endmodule
